// File: rtl/k6502_seq.sv
// k6502_seq: instruction sequencer for the k6502 core.
// Holds the opcode register and the one-hot cycle counter that address the
// microcode ROM. Advances them from the ROM NEXT bit, chooses between the
// fetched opcode and a pending NMI or IRQ, and aborts an instruction that
// runs past C_5 without asserting NEXT.
module k6502_seq #(
  parameter logic [7:0] RESET_OP = 8'h00,
  parameter logic [7:0] INT_OP   = 8'h00
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rdy_i,
  input  logic [7:0] di_i,
  input  logic       next_i,
  input  logic       nmi_n_i,
  input  logic       irq_n_i,
  input  logic       i_flag_i,
  output logic [7:0] ir_o,
  output logic [5:0] cycle_o,
  output logic       sync_o,
  output logic       int_ack_o,
  output logic       int_nmi_o,
  output logic       bad_op_o
);

  // Cycle encodings: all-zero is the fetch cycle, C_0..C_5 are one-hot.
  localparam logic [5:0] C_N = 6'b000000;
  localparam logic [5:0] C_0 = 6'b000001;
  localparam logic [5:0] C_5 = 6'b100000;

  logic [7:0] ir_q,       ir_d;
  logic [5:0] cycle_q,    cycle_d;
  logic       int_ack_q,  int_ack_d;
  logic       int_nmi_q,  int_nmi_d;
  logic       bad_op_q,   bad_op_d;
  logic       nmi_pend_q, nmi_pend_d;
  logic       nmi_prev_q, nmi_prev_d;

  logic fetch;
  logic nmi_edge;
  logic take_nmi;
  logic take_irq;
  logic cycle_onehot;

  assign fetch        = (cycle_q == C_N);
  assign nmi_edge     = nmi_prev_q & ~nmi_n_i;
  assign take_nmi     = fetch & nmi_pend_q;
  assign take_irq     = fetch & ~nmi_pend_q & ~irq_n_i & ~i_flag_i;
  // A multi-hot counter cannot occur normally; it falls into the watchdog.
  assign cycle_onehot = (cycle_q != C_N) && ((cycle_q & (cycle_q - 6'd1)) == 6'd0);

  // State register: updates only while the bus is ready.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values of the others; blocking here would create order-dependent races.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ir_q       <= RESET_OP;
      cycle_q    <= C_N;
      int_ack_q  <= 1'b0;
      int_nmi_q  <= 1'b0;
      bad_op_q   <= 1'b0;
      nmi_pend_q <= 1'b0;
      nmi_prev_q <= 1'b1;
    end else if (rdy_i) begin
      ir_q       <= ir_d;
      cycle_q    <= cycle_d;
      int_ack_q  <= int_ack_d;
      int_nmi_q  <= int_nmi_d;
      bad_op_q   <= bad_op_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_prev_q <= nmi_prev_d;
    end
  end

  // Next-state: fetch arbitration, cycle advance, watchdog and NMI latch.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    ir_d       = ir_q;
    cycle_d    = cycle_q;
    int_ack_d  = 1'b0;
    int_nmi_d  = int_nmi_q;
    bad_op_d   = 1'b0;
    nmi_prev_d = nmi_n_i;
    nmi_pend_d = nmi_pend_q;

    // A new edge wins over the clear caused by taking the NMI.
    if (nmi_edge) begin
      nmi_pend_d = 1'b1;
    end else if (take_nmi) begin
      nmi_pend_d = 1'b0;
    end

    if (fetch) begin
      cycle_d = C_0;
      if (take_nmi) begin
        ir_d      = INT_OP;
        int_ack_d = 1'b1;
        int_nmi_d = 1'b1;
      end else if (take_irq) begin
        ir_d      = INT_OP;
        int_ack_d = 1'b1;
        int_nmi_d = 1'b0;
      end else begin
        ir_d = di_i;
      end
    end else if (!cycle_onehot) begin
      cycle_d  = C_N;
      bad_op_d = 1'b1;
    end else if (next_i) begin
      cycle_d = C_N;
    end else if (cycle_q != C_5) begin
      cycle_d = cycle_q << 1;
    end else begin
      cycle_d  = C_N;
      bad_op_d = 1'b1;
    end
  end

  // Outputs: registered state plus the combinational fetch indicator.
  always_comb begin
    ir_o      = ir_q;
    cycle_o   = cycle_q;
    sync_o    = (cycle_q == C_N);
    int_ack_o = int_ack_q;
    int_nmi_o = int_nmi_q;
    bad_op_o  = bad_op_q;
  end

endmodule

// File: tb/tb_k6502_seq.sv
// tb_k6502_seq: directed vectors for k6502_seq with a queued scoreboard.
// Stimulus pushes the expected post-edge state; the monitor pops one entry
// after each rising edge (or after an asynchronous-reset event) and compares.
module tb_k6502_seq;

  localparam logic [7:0] INT_OP = 8'h5C;

  logic       clk = 1'b0;
  logic       reset;
  logic       rdy;
  logic [7:0] di;
  logic       next;
  logic       nmi_n;
  logic       irq_n;
  logic       i_flag;
  logic [7:0] ir;
  logic [5:0] cycle;
  logic       sync;
  logic       int_ack;
  logic       int_nmi;
  logic       bad_op;

  k6502_seq #(.RESET_OP(8'h00), .INT_OP(INT_OP)) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .rdy_i    (rdy),
    .di_i     (di),
    .next_i   (next),
    .nmi_n_i  (nmi_n),
    .irq_n_i  (irq_n),
    .i_flag_i (i_flag),
    .ir_o     (ir),
    .cycle_o  (cycle),
    .sync_o   (sync),
    .int_ack_o(int_ack),
    .int_nmi_o(int_nmi),
    .bad_op_o (bad_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [17:0] v;   // {ir, cycle, sync, int_ack, int_nmi, bad_op}
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  event async_ev;

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got ir=%h cyc=%b sync=%b ack=%b nmi=%b bad=%b, want ir=%h cyc=%b sync=%b ack=%b nmi=%b bad=%b",
               name, act[17:10], act[9:4], act[3], act[2], act[1], act[0],
               exp[17:10], exp[9:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [17:0] pack(input logic [7:0] e_ir, input logic [5:0] e_cyc,
                                       input logic e_ack, input logic e_nmi, input logic e_bad);
    return {e_ir, e_cyc, (e_cyc == 6'd0), e_ack, e_nmi, e_bad};
  endfunction

  // Monitor: compare the oldest expectation against the DUT after each event.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or async_ev);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, {ir, cycle, sync, int_ack, int_nmi, bad_op}, e.v);
      end
    end
  end

  // Drive one clock of inputs at the falling edge and queue the expected state
  // after the following rising edge.
  task automatic step(input logic r, input logic [7:0] d, input logic nx,
                      input logic nmi, input logic irq, input logic ifl,
                      input logic [7:0] e_ir, input logic [5:0] e_cyc,
                      input logic e_ack, input logic e_nmi, input logic e_bad,
                      input string name);
    exp_t e;
    rdy    = r;
    di     = d;
    next   = nx;
    nmi_n  = nmi;
    irq_n  = irq;
    i_flag = ifl;
    e.name = name;
    e.v    = pack(e_ir, e_cyc, e_ack, e_nmi, e_bad);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic async_check(input logic [7:0] e_ir, input logic [5:0] e_cyc,
                             input logic e_ack, input logic e_nmi, input logic e_bad,
                             input string name);
    exp_t e;
    e.name = name;
    e.v    = pack(e_ir, e_cyc, e_ack, e_nmi, e_bad);
    exp_q.push_back(e);
    ->async_ev;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; rdy = 1'b1; di = 8'h00; next = 1'b0;
    nmi_n = 1'b1; irq_n = 1'b1; i_flag = 1'b1;
    #3;
    async_check(8'h00, 6'b000000, 1'b0, 1'b0, 1'b0, "reset_state");
    @(negedge clk);
    reset = 1'b0;

    //    rdy  di     nx  nmi irq if   ir     cycle      ack nmi bad
    // Basic fetch and NEXT at C_1.
    step(1, 8'hA9, 0, 1, 1, 1, 8'hA9, 6'b000001, 0, 0, 0, "fetch_a9");
    step(1, 8'h00, 0, 1, 1, 1, 8'hA9, 6'b000010, 0, 0, 0, "a9_c1");
    step(1, 8'h00, 1, 1, 1, 1, 8'hA9, 6'b000000, 0, 0, 0, "a9_next");

    // Freeze at C_1 with an NMI pulse hidden under rdy=0.
    step(1, 8'h8D, 0, 1, 1, 1, 8'h8D, 6'b000001, 0, 0, 0, "fetch_8d");
    step(1, 8'h00, 0, 1, 1, 1, 8'h8D, 6'b000010, 0, 0, 0, "8d_c1");
    step(0, 8'hFF, 1, 1, 1, 1, 8'h8D, 6'b000010, 0, 0, 0, "freeze_1");
    step(0, 8'hFF, 1, 0, 1, 1, 8'h8D, 6'b000010, 0, 0, 0, "freeze_2");
    step(0, 8'hFF, 1, 1, 1, 1, 8'h8D, 6'b000010, 0, 0, 0, "freeze_3");
    step(1, 8'h00, 0, 1, 1, 1, 8'h8D, 6'b000100, 0, 0, 0, "resume_c2");
    step(1, 8'h00, 1, 1, 1, 1, 8'h8D, 6'b000000, 0, 0, 0, "resume_next");
    step(1, 8'hEA, 0, 1, 1, 1, 8'hEA, 6'b000001, 0, 0, 0, "no_nmi_after_freeze");
    step(1, 8'h00, 1, 1, 1, 1, 8'hEA, 6'b000000, 0, 0, 0, "ea_next");

    // NMI edge and IRQ together at C_0: NMI first, then IRQ.
    step(1, 8'h20, 0, 1, 1, 1, 8'h20, 6'b000001, 0, 0, 0, "fetch_20");
    step(1, 8'h00, 1, 0, 0, 0, 8'h20, 6'b000000, 0, 0, 0, "nmi_edge_c0");
    step(1, 8'h4C, 0, 0, 0, 0, INT_OP, 6'b000001, 1, 1, 0, "take_nmi");
    step(1, 8'h00, 1, 1, 0, 0, INT_OP, 6'b000000, 0, 1, 0, "nmi_ack_drop");
    step(1, 8'h4C, 0, 1, 0, 0, INT_OP, 6'b000001, 1, 0, 0, "take_irq");
    step(0, 8'h00, 1, 1, 1, 1, INT_OP, 6'b000001, 1, 0, 0, "ack_held_rdy0");
    step(1, 8'h00, 1, 1, 1, 1, INT_OP, 6'b000000, 0, 0, 0, "irq_next");

    // IRQ masked by the I flag.
    step(1, 8'hEA, 0, 1, 0, 1, 8'hEA, 6'b000001, 0, 0, 0, "irq_masked");
    step(1, 8'h00, 1, 1, 0, 1, 8'hEA, 6'b000000, 0, 0, 0, "masked_next");

    // Unimplemented opcode: walk to C_5, then watchdog abort.
    step(1, 8'h02, 0, 1, 1, 1, 8'h02, 6'b000001, 0, 0, 0, "fetch_02");
    step(1, 8'h00, 0, 1, 1, 1, 8'h02, 6'b000010, 0, 0, 0, "wd_c1");
    step(1, 8'h00, 0, 1, 1, 1, 8'h02, 6'b000100, 0, 0, 0, "wd_c2");
    step(1, 8'h00, 0, 1, 1, 1, 8'h02, 6'b001000, 0, 0, 0, "wd_c3");
    step(1, 8'h00, 0, 1, 1, 1, 8'h02, 6'b010000, 0, 0, 0, "wd_c4");
    step(1, 8'h00, 0, 1, 1, 1, 8'h02, 6'b100000, 0, 0, 0, "wd_c5");
    step(1, 8'h00, 0, 1, 1, 1, 8'h02, 6'b000000, 0, 0, 1, "wd_abort");
    step(1, 8'hEA, 0, 1, 1, 1, 8'hEA, 6'b000001, 0, 0, 0, "bad_op_clears");
    step(1, 8'h00, 1, 1, 1, 1, 8'hEA, 6'b000000, 0, 0, 0, "after_wd_next");

    // Asynchronous reset in the middle of 8'hAD at C_3.
    step(1, 8'hAD, 0, 1, 1, 1, 8'hAD, 6'b000001, 0, 0, 0, "fetch_ad");
    step(1, 8'h00, 0, 1, 1, 1, 8'hAD, 6'b000010, 0, 0, 0, "ad_c1");
    step(1, 8'h00, 0, 1, 1, 1, 8'hAD, 6'b000100, 0, 0, 0, "ad_c2");
    step(1, 8'h00, 0, 1, 1, 1, 8'hAD, 6'b001000, 0, 0, 0, "ad_c3");
    reset = 1'b1;
    async_check(8'h00, 6'b000000, 1'b0, 1'b0, 1'b0, "async_reset");
    @(negedge clk);
    reset = 1'b0;
    step(1, 8'hA9, 0, 1, 1, 1, 8'hA9, 6'b000001, 0, 0, 0, "fetch_after_reset");

    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/k6502_seq.md
# k6502_seq

Instruction sequencer for the k6502 core. It owns the opcode register `ir` and the one-hot `cycle` counter that together index the microcode ROM, and advances them from the ROM's NEXT bit. It also arbitrates opcode fetch between memory, pending NMI and IRQ, and recovers from unimplemented opcodes. It sits between the bus interface (`di`, `rdy`) and the microcode ROM input `{ir, cycle}`.

## Interface
- `RESET_OP`, default 8'h00: opcode loaded into `ir` on reset (reset microcode row).
- `INT_OP`, default 8'h00: opcode forced into `ir` when an interrupt is taken.
- `clk` in 1: core clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `rdy` in 1: bus ready; 0 freezes all sequencer state.
- `di` in 8: data bus input; the opcode byte during the fetch cycle.
- `next` in 1: NEXT bit of the current microcode word (combinational from ROM).
- `nmi_n` in 1: NMI request, falling-edge sensitive.
- `irq_n` in 1: IRQ request, low-level sensitive.
- `i_flag` in 1: processor I flag; 1 masks IRQ.
- `ir` out 8: current opcode, registered.
- `cycle` out 6: 6'b000000 = fetch (C_N); 6'b000001..6'b100000 = C_0..C_5, one-hot, registered.
- `sync` out 1: combinational, `cycle == 0`.
- `int_ack` out 1: registered one-cycle pulse when an interrupt replaces the fetched opcode.
- `int_nmi` out 1: registered source of the last taken interrupt (1 = NMI, 0 = IRQ); held until the next take.
- `bad_op` out 1: registered one-cycle pulse on a watchdog abort.

## Operation
- Reset values: `ir` = RESET_OP, `cycle` = 0, `int_ack` = 0, `int_nmi` = 0, `bad_op` = 0, `nmi_pend` = 0, `nmi_d` = 1. `sync` is therefore 1 out of reset.
- Every state update below, including NMI edge capture, occurs only on edges where `rdy` = 1. When `rdy` = 0, all registers hold; `int_ack` and `bad_op` also hold.
- NMI edge detect:
  - `nmi_d` <= `nmi_n`.
  - Set `nmi_pend` when `nmi_d` = 1 and `nmi_n` = 0.
  - Clear `nmi_pend` when an NMI is taken. If a new edge and a take coincide, set wins.
- Fetch cycle (`cycle` = 0), priority order:
  - NMI (`nmi_pend` = 1): `ir` <= INT_OP, `int_ack` <= 1, `int_nmi` <= 1.
  - IRQ (`irq_n` = 0 and `i_flag` = 0): `ir` <= INT_OP, `int_ack` <= 1, `int_nmi` <= 0.
  - Otherwise: `ir` <= `di`.
  - In all three cases `cycle` <= C_0. `next` is ignored in the fetch cycle.
- Execute cycles (C_0..C_5):
  - `next` = 1: `cycle` <= 0 and `ir` holds.
  - `next` = 0 and cycle < C_5: `cycle` <= `cycle` << 1.
  - `next` = 0 and cycle = C_5 (watchdog): `cycle` <= 0, `bad_op` <= 1.
- `int_ack` and `bad_op` are 0 on every enabled edge where their set condition is false.
- IRQ is sampled only in the fetch cycle. NMI is latched in any cycle.

## Timing
- `next` → `cycle` latency: one edge. An instruction asserting `next` at C_k spends k+2 clocks, counting the fetch cycle.
- Opcode byte on `di` during fetch is visible on `ir` one edge later, together with `cycle` = C_0.
- `int_ack`/`int_nmi` go valid on the same edge that `ir` becomes INT_OP.
- Reset mid-instruction: `ir` and `cycle` return to reset values immediately (asynchronous); `nmi_pend` is discarded.
- Illegal `cycle` encodings (multi-hot) cannot occur; if forced, they are treated as the watchdog case on the next enabled edge.

## Test plan
- Reset release, `di` = 8'hA9: edge 1 gives `ir` = A9, `cycle` = 000001. With `next` = 1 at C_1, edge 3 gives `cycle` = 0 and `sync` = 1.
- `rdy` = 0 for 3 clocks at C_1 with `nmi_n` toggled 1→0→1: `ir`/`cycle` frozen and `nmi_pend` stays 0. After `rdy` returns to 1, the sequence resumes exactly.
- NMI edge at C_0 with `irq_n` = 0 and `i_flag` = 0 simultaneously: the next fetch yields `ir` = INT_OP, `int_ack` = 1 for one clock and `int_nmi` = 1. The following fetch takes IRQ with `int_nmi` = 0.
- `irq_n` = 0 with `i_flag` = 1, `di` = 8'hEA: `ir` = EA and `int_ack` stays 0.
- Opcode 8'h02 with `next` never asserted: `cycle` walks 000001→100000, then goes to 0 with `bad_op` pulsed once, 7 clocks after fetch.
- `reset` asserted at C_3 of 8'hAD for half a clock: `ir` = 00 and `cycle` = 0 immediately, with no clock edge needed.
